// File: rtl/cam_pkg.sv
// Shared definitions for the camera pixel-bus generator and capture blocks:
// FSM states, default frame timing and RGB444 byte packing.
package cam_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_HBLANK,
        S_VFRONT
    } cam_state_t;

    localparam int DEF_AW          = 15;
    localparam int DEF_H_ACTIVE    = 160;
    localparam int DEF_V_ACTIVE    = 120;
    localparam int DEF_H_BLANK     = 144;
    localparam int DEF_VSYNC_LINES = 3;
    localparam int DEF_V_BACK      = 17;
    localparam int DEF_V_FRONT     = 10;

    localparam int         BYTES_PER_PX = 2;
    localparam logic [3:0] RGB444_PAD   = 4'h0;

    // First byte on the bus carries red in its low nibble.
    function automatic logic [7:0] rgb444_hi(input logic [11:0] px);
        return {RGB444_PAD, px[11:8]};
    endfunction

    function automatic logic [7:0] rgb444_lo(input logic [11:0] px);
        return px[7:0];
    endfunction

endpackage

// File: rtl/cam_timing_cnt.sv
// PCLK divider plus position counters: PCLK period within a line and
// line-time within the current frame period, with end-of-line/period strobes.
module cam_timing_cnt #(
    parameter int LINE_LEN = 464,
    parameter int CW       = 9,
    parameter int LW       = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [LW-1:0] period_len,
    output logic          pclk,
    output logic          tick,
    output logic [CW-1:0] pclk_cnt,
    output logic          eol,
    output logic          eop
);

    logic [LW-1:0] line_cnt;

    // tick marks the clk edge on which PCLK falls; all bus updates happen there.
    assign tick = run & pclk;
    assign eol  = tick && (pclk_cnt == CW'(LINE_LEN - 1));
    assign eop  = eol && (line_cnt == period_len - 1'b1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pclk     <= 1'b0;
            pclk_cnt <= '0;
            line_cnt <= '0;
        end else begin
            pclk <= run ? ~pclk : 1'b0;
            if (tick) begin
                pclk_cnt <= eol ? '0 : pclk_cnt + 1'b1;
                if (eop)
                    line_cnt <= '0;
                else if (eol)
                    line_cnt <= line_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_stream_gen.sv
// OV7670-style RGB444 transmitter: reads pixels from a synchronous frame
// memory and drives the PCLK/VSYNC/HREF/byte stream a capture block expects.
module cam_stream_gen
    import cam_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int V_FRONT     = DEF_V_FRONT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          continuous,
    input  logic          stop,
    output logic [AW-1:0] rd_addr,
    input  logic [11:0]   rd_data,
    output logic          CAM_PCLK,
    output logic          CAM_VSYNC,
    output logic          CAM_HREF,
    output logic [7:0]    CAM_px_data,
    output logic          busy,
    output logic          frame_done
);

    localparam int LINE_LEN  = BYTES_PER_PX * H_ACTIVE + H_BLANK;
    localparam int CW        = $clog2(LINE_LEN);
    localparam int V_MAX_A   = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
    localparam int V_MAX_B   = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
    localparam int V_MAX     = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
    localparam int LW        = $clog2(V_MAX + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(H_ACTIVE * V_ACTIVE - 1);

    cam_state_t    state;
    logic          stop_pending;
    logic [11:0]   px_hold;
    logic [LW-1:0] period_len;
    logic [CW-1:0] pclk_cnt;
    logic          tick;
    logic          eol;
    logic          eop;

    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        period_len = LW'(V_ACTIVE);
        case (state)
            S_VSYNC:  period_len = LW'(VSYNC_LINES);
            S_VBACK:  period_len = LW'(V_BACK);
            S_VFRONT: period_len = LW'(V_FRONT);
            default:  period_len = LW'(V_ACTIVE);
        endcase
    end

    cam_timing_cnt #(
        .LINE_LEN (LINE_LEN),
        .CW       (CW),
        .LW       (LW)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .run        (busy),
        .period_len (period_len),
        .pclk       (CAM_PCLK),
        .tick       (tick),
        .pclk_cnt   (pclk_cnt),
        .eol        (eol),
        .eop        (eop)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            stop_pending <= 1'b0;
            frame_done   <= 1'b0;
            rd_addr      <= '0;
            px_hold      <= '0;
            CAM_VSYNC    <= 1'b0;
            CAM_HREF     <= 1'b0;
            CAM_px_data  <= '0;
        end else begin
            frame_done <= 1'b0;
            if (busy && stop)
                stop_pending <= 1'b1;

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_VSYNC;
                        busy    <= 1'b1;
                        rd_addr <= '0;
                    end
                end
                S_VSYNC: if (tick) begin
                    CAM_VSYNC <= 1'b1;
                    if (eop)
                        state <= S_VBACK;
                end
                S_VBACK: if (tick) begin
                    CAM_VSYNC <= 1'b0;
                    if (eop)
                        state <= S_ACTIVE;
                end
                S_ACTIVE: if (tick) begin
                    CAM_HREF <= 1'b1;
                    // Even bytes latch the pixel that rd_addr has had two clks to fetch.
                    if (!pclk_cnt[0]) begin
                        px_hold     <= rd_data;
                        CAM_px_data <= rgb444_hi(rd_data);
                    end else begin
                        CAM_px_data <= rgb444_lo(px_hold);
                        if (rd_addr != LAST_ADDR)
                            rd_addr <= rd_addr + 1'b1;
                    end
                    if (pclk_cnt == CW'(BYTES_PER_PX * H_ACTIVE - 1))
                        state <= S_HBLANK;
                end
                S_HBLANK: if (tick) begin
                    CAM_HREF    <= 1'b0;
                    CAM_px_data <= '0;
                    if (eop)
                        state <= S_VFRONT;
                    else if (eol)
                        state <= S_ACTIVE;
                end
                S_VFRONT: if (tick && eop) begin
                    frame_done <= 1'b1;
                    if (continuous && !stop_pending) begin
                        state   <= S_VSYNC;
                        rd_addr <= '0;
                    end else begin
                        state        <= S_IDLE;
                        busy         <= 1'b0;
                        stop_pending <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
